// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
//
// Purpose:
//   Execute-stage branch resolution.  It evaluates conditional branches, JAL
//   and JALR on raw register operands. It produces the resolved direction,
//   the next PC and the link value, and compares them with the front-end
//   prediction to raise a redirect (mispredict) towards fetch.
//   The unit has two registered stages with valid/ready handshakes on both
//   sides:
//     E1 : condition evaluation, target adder, link adder
//     E2 : resolution against the prediction (registered outputs)
//   An output transfer that mispredicts discards the younger entry held in E1,
//   together with any entry accepted in the same cycle, because those entries
//   are on the wrong path.  i_flush empties both stages at the next edge.
//
// Parameters:
//   XLEN   datapath width (32 or 64)
//   TAG_W  width of the opaque instruction tag carried alongside the entry
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_flush                kill every in-flight entry
//   i_valid / o_ready      input handshake
//   i_kind                 00 cond branch, 01 JAL, 10 JALR, 11 non-control
//   i_func3                branch condition (RV encoding)
//   i_r1, i_r2             register operands
//   i_pc, i_imm            instruction PC, sign-extended immediate
//   i_pred_taken/_target   front-end prediction
//   i_tag                  instruction tag
//   o_valid / i_ready      output handshake
//   o_taken, o_target      resolved direction and next PC
//   o_link                 pc+4 (JAL/JALR writeback value)
//   o_mispredict           redirect required
//   o_misaligned           taken target not 4-byte aligned
//   o_tag                  tag of the presented result
//   o_br_count, o_mp_count statistics counters
//
// Optional feature:
//   BRANCH_RESOLVE_STATS_EN  when defined, o_br_count counts output transfers
//   of control-flow entries and o_mp_count counts mispredicting transfers.
//   When it is not defined, both outputs are tied to zero.
// -----------------------------------------------------------------------------
module branch_resolve_unit #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_kind,
  input  logic [2:0]       i_func3,
  input  logic [XLEN-1:0]  i_r1,
  input  logic [XLEN-1:0]  i_r2,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_pred_taken,
  input  logic [XLEN-1:0]  i_pred_target,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic [XLEN-1:0]  o_target,
  output logic [XLEN-1:0]  o_link,
  output logic             o_mispredict,
  output logic             o_misaligned,
  output logic [TAG_W-1:0] o_tag,
  output logic [31:0]      o_br_count,
  output logic [31:0]      o_mp_count
);

  localparam logic [1:0]      KIND_BRANCH = 2'b00;
  localparam logic [1:0]      KIND_JAL    = 2'b01;
  localparam logic [1:0]      KIND_JALR   = 2'b10;
  localparam logic [1:0]      KIND_NONE   = 2'b11;
  localparam logic [XLEN-1:0] PC_STEP     = XLEN'(4);

  // ---------------------------------------------------------------------------
  // Stage E1 state
  // ---------------------------------------------------------------------------
  logic             e1_valid_q,       e1_valid_d;
  logic [1:0]       e1_kind_q,        e1_kind_d;
  logic             e1_taken_q,       e1_taken_d;
  logic [XLEN-1:0]  e1_dest_q,        e1_dest_d;
  logic [XLEN-1:0]  e1_link_q,        e1_link_d;
  logic             e1_pred_taken_q,  e1_pred_taken_d;
  logic [XLEN-1:0]  e1_pred_target_q, e1_pred_target_d;
  logic [TAG_W-1:0] e1_tag_q,         e1_tag_d;

  // ---------------------------------------------------------------------------
  // Stage E2 state (drives the outputs directly)
  // ---------------------------------------------------------------------------
  logic             e2_valid_q,  e2_valid_d;
  logic             e2_taken_q,  e2_taken_d;
  logic [XLEN-1:0]  e2_target_q, e2_target_d;
  logic [XLEN-1:0]  e2_link_q,   e2_link_d;
  logic             e2_mp_q,     e2_mp_d;
  logic             e2_mis_q,    e2_mis_d;
  logic [TAG_W-1:0] e2_tag_q,    e2_tag_d;

  // ---------------------------------------------------------------------------
  // E1 datapath: condition, target adder, link adder
  // ---------------------------------------------------------------------------
  logic            cond_taken;
  logic            in_taken;
  logic [XLEN-1:0] add_base;
  logic [XLEN-1:0] add_sum;
  logic [XLEN-1:0] in_dest;
  logic [XLEN-1:0] in_link;

  always_comb begin
    cond_taken = 1'b0;
    case (i_func3)
      3'b000:  cond_taken = (i_r1 == i_r2);
      3'b001:  cond_taken = (i_r1 != i_r2);
      3'b100:  cond_taken = ($signed(i_r1) <  $signed(i_r2));
      3'b101:  cond_taken = ($signed(i_r1) >= $signed(i_r2));
      3'b110:  cond_taken = (i_r1 <  i_r2);
      3'b111:  cond_taken = (i_r1 >= i_r2);
      default: cond_taken = 1'b0;  // 010/011 are not branch conditions
    endcase
  end

  always_comb begin
    in_taken = 1'b0;
    case (i_kind)
      KIND_BRANCH:        in_taken = cond_taken;
      KIND_JAL, KIND_JALR: in_taken = 1'b1;
      default:            in_taken = 1'b0;
    endcase
  end

  // One shared adder: JALR adds to r1, everything else adds to the PC.
  always_comb begin
    add_base = (i_kind == KIND_JALR) ? i_r1 : i_pc;
    add_sum  = add_base + i_imm;
    // JALR clears bit 0 of the computed target.
    in_dest  = (i_kind == KIND_JALR) ? {add_sum[XLEN-1:1], 1'b0} : add_sum;
    in_link  = i_pc + PC_STEP;
  end

  // ---------------------------------------------------------------------------
  // E2 datapath: resolution against the prediction
  // ---------------------------------------------------------------------------
  logic            res_mp;
  logic            res_mis;
  logic [XLEN-1:0] res_target;

  always_comb begin
    res_target = e1_taken_q ? e1_dest_q : e1_link_q;
    // A not-taken entry mispredicts exactly when it was predicted taken; a
    // taken entry also mispredicts on a wrong target.  Non-control entries
    // never redirect.
    res_mp     = (e1_kind_q != KIND_NONE) &&
                 ((e1_taken_q != e1_pred_taken_q) ||
                  (e1_taken_q && (e1_dest_q != e1_pred_target_q)));
    res_mis    = e1_taken_q && (res_target[1:0] != 2'b00);
  end

  // ---------------------------------------------------------------------------
  // Handshake and squash control
  // ---------------------------------------------------------------------------
  logic e1_adv;
  logic out_xfer;
  logic in_xfer;
  logic squash;
  logic e1_load;
  logic e2_load;

  always_comb begin
    e1_adv   = !e2_valid_q || i_ready;
    out_xfer = e2_valid_q && i_ready;
    // A mispredicting result leaving the unit makes everything younger stale.
    squash   = out_xfer && e2_mp_q;
    in_xfer  = i_valid && o_ready;
    e1_load  = in_xfer && !squash && !i_flush;
    e2_load  = e1_adv && e1_valid_q && !squash && !i_flush;
  end

  // o_ready intentionally ignores i_flush; flushed input is simply dropped.
  assign o_ready = !e1_valid_q || e1_adv;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    e1_valid_d       = e1_valid_q;
    e1_kind_d        = e1_kind_q;
    e1_taken_d       = e1_taken_q;
    e1_dest_d        = e1_dest_q;
    e1_link_d        = e1_link_q;
    e1_pred_taken_d  = e1_pred_taken_q;
    e1_pred_target_d = e1_pred_target_q;
    e1_tag_d         = e1_tag_q;

    e2_valid_d       = e2_valid_q;
    e2_taken_d       = e2_taken_q;
    e2_target_d      = e2_target_q;
    e2_link_d        = e2_link_q;
    e2_mp_d          = e2_mp_q;
    e2_mis_d         = e2_mis_q;
    e2_tag_d         = e2_tag_q;

    // Whenever E1 can move, it either refills from the input or empties.
    if (i_flush) begin
      e1_valid_d = 1'b0;
    end else if (o_ready) begin
      e1_valid_d = e1_load;
    end

    if (i_flush) begin
      e2_valid_d = 1'b0;
    end else if (e1_adv) begin
      e2_valid_d = e2_load;
    end

    // Data registers only load with a live entry, so a stalled result holds.
    if (e1_load) begin
      e1_kind_d        = i_kind;
      e1_taken_d       = in_taken;
      e1_dest_d        = in_dest;
      e1_link_d        = in_link;
      e1_pred_taken_d  = i_pred_taken;
      e1_pred_target_d = i_pred_target;
      e1_tag_d         = i_tag;
    end

    if (e2_load) begin
      e2_taken_d  = e1_taken_q;
      e2_target_d = res_target;
      e2_link_d   = e1_link_q;
      e2_mp_d     = res_mp;
      e2_mis_d    = res_mis;
      e2_tag_d    = e1_tag_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e1_valid_q       <= 1'b0;
      e1_kind_q        <= '0;
      e1_taken_q       <= 1'b0;
      e1_dest_q        <= '0;
      e1_link_q        <= '0;
      e1_pred_taken_q  <= 1'b0;
      e1_pred_target_q <= '0;
      e1_tag_q         <= '0;
      e2_valid_q       <= 1'b0;
      e2_taken_q       <= 1'b0;
      e2_target_q      <= '0;
      e2_link_q        <= '0;
      e2_mp_q          <= 1'b0;
      e2_mis_q         <= 1'b0;
      e2_tag_q         <= '0;
    end else begin
      e1_valid_q       <= e1_valid_d;
      e1_kind_q        <= e1_kind_d;
      e1_taken_q       <= e1_taken_d;
      e1_dest_q        <= e1_dest_d;
      e1_link_q        <= e1_link_d;
      e1_pred_taken_q  <= e1_pred_taken_d;
      e1_pred_target_q <= e1_pred_target_d;
      e1_tag_q         <= e1_tag_d;
      e2_valid_q       <= e2_valid_d;
      e2_taken_q       <= e2_taken_d;
      e2_target_q      <= e2_target_d;
      e2_link_q        <= e2_link_d;
      e2_mp_q          <= e2_mp_d;
      e2_mis_q         <= e2_mis_d;
      e2_tag_q         <= e2_tag_d;
    end
  end

  assign o_valid      = e2_valid_q;
  assign o_taken      = e2_taken_q;
  assign o_target     = e2_target_q;
  assign o_link       = e2_link_q;
  assign o_mispredict = e2_mp_q;
  assign o_misaligned = e2_mis_q;
  assign o_tag        = e2_tag_q;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [1:0]  e2_kind_q,  e2_kind_d;
  logic [31:0] br_count_q, br_count_d;
  logic [31:0] mp_count_q, mp_count_d;

  always_comb begin
    e2_kind_d  = e2_kind_q;
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (e2_load) begin
      e2_kind_d = e1_kind_q;
    end
    // Counting happens on the transfer itself, so a flush in the same cycle
    // does not hide it.
    if (out_xfer && (e2_kind_q != KIND_NONE)) begin
      br_count_d = br_count_q + 32'd1;
    end
    if (out_xfer && e2_mp_q) begin
      mp_count_d = mp_count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      e2_kind_q  <= '0;
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      e2_kind_q  <= e2_kind_d;
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign o_br_count = br_count_q;
  assign o_mp_count = mp_count_q;
`else
  assign o_br_count = 32'd0;
  assign o_mp_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Scoreboard bench for branch_resolve_unit.  Each accepted input has its
// expected result (from a behavioural model of the branch rules) pushed into a
// queue; a monitor pops and compares on every output transfer.  Wrong-path
// squash, flush and reset are modelled as "everything accepted up to cycle N
// is dead", applied lazily when the queue is popped.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;

  localparam int XLEN  = 32;
  localparam int TAG_W = 6;
`ifdef BRANCH_RESOLVE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             out_ready_dut;
  logic [1:0]       kind;
  logic [2:0]       func3;
  logic [XLEN-1:0]  r1, r2, pc, imm;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             ds_ready;
  logic             taken;
  logic [XLEN-1:0]  target, link;
  logic             mispredict, misaligned;
  logic [TAG_W-1:0] out_tag;
  logic [31:0]      br_count, mp_count;

  branch_resolve_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_valid(in_valid), .o_ready(out_ready_dut),
    .i_kind(kind), .i_func3(func3), .i_r1(r1), .i_r2(r2),
    .i_pc(pc), .i_imm(imm), .i_pred_taken(pred_taken),
    .i_pred_target(pred_target), .i_tag(tag),
    .o_valid(out_valid), .i_ready(ds_ready),
    .o_taken(taken), .o_target(target), .o_link(link),
    .o_mispredict(mispredict), .o_misaligned(misaligned), .o_tag(out_tag),
    .o_br_count(br_count), .o_mp_count(mp_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [31:0] r1, r2, pc, imm;
    logic        pt;
    logic [31:0] ptgt;
    logic [5:0]  tag;
  } stim_t;

  typedef struct packed {
    logic [1:0]  kind;
    logic        taken;
    logic [31:0] target, link;
    logic        mp, mis;
    logic [5:0]  tag;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   kill_cycle = -1;
  int   out_count = 0;
  int   exp_br = 0;
  int   exp_mp = 0;
  int   tag_n = 0;

  // Behavioural reference: branch rules straight from the ISA description.
  function automatic exp_t model(input stim_t s);
    exp_t e;
    logic [31:0] dest;
    e = '0;
    e.kind = s.kind;
    e.tag  = s.tag;
    e.link = s.pc + 32'd4;
    case (s.kind)
      2'd0: begin
        case (s.f3)
          3'd0: e.taken = (s.r1 == s.r2);
          3'd1: e.taken = (s.r1 != s.r2);
          3'd4: e.taken = ($signed(s.r1) <  $signed(s.r2));
          3'd5: e.taken = ($signed(s.r1) >= $signed(s.r2));
          3'd6: e.taken = (s.r1 <  s.r2);
          3'd7: e.taken = (s.r1 >= s.r2);
          default: e.taken = 1'b0;
        endcase
      end
      2'd1, 2'd2: e.taken = 1'b1;
      default:    e.taken = 1'b0;
    endcase
    dest     = (s.kind == 2'd2) ? ((s.r1 + s.imm) & 32'hFFFF_FFFE) : (s.pc + s.imm);
    e.target = e.taken ? dest : e.link;
    e.mp     = (s.kind != 2'd3) && ((e.taken != s.pt) || (e.taken && (dest != s.ptgt)));
    e.mis    = e.taken && (e.target[1:0] != 2'b00);
    return e;
  endfunction

  function automatic stim_t mk(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                               input logic t, input logic [31:0] tg, input logic [5:0] id);
    stim_t s;
    s.kind = k; s.f3 = f; s.r1 = a; s.r2 = b; s.pc = p; s.imm = i;
    s.pt = t; s.ptgt = tg; s.tag = id;
    return s;
  endfunction

  function automatic stim_t rand_stim(input bit correct, input logic [5:0] id);
    stim_t s;
    exp_t  e;
    logic [11:0] i12;
    i12    = 12'($urandom);
    s.kind = 2'($urandom_range(0, 3));
    s.f3   = 3'($urandom_range(0, 7));
    s.r1   = $urandom;
    s.r2   = ($urandom_range(0, 2) == 0) ? s.r1 : $urandom;
    s.pc   = $urandom & 32'hFFFF_FFFC;
    s.imm  = {{20{i12[11]}}, i12};
    s.pt   = 1'($urandom_range(0, 1));
    s.ptgt = $urandom;
    s.tag  = id;
    e = model(s);
    if (correct) begin
      s.pt   = e.taken;
      s.ptgt = e.target;
    end else if ($urandom_range(0, 1) == 1) begin
      s.ptgt = e.target;
    end
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input stim_t s);
    kind = s.kind; func3 = s.f3; r1 = s.r1; r2 = s.r2; pc = s.pc; imm = s.imm;
    pred_taken = s.pt; pred_target = s.ptgt; tag = s.tag;
    in_valid = 1'b1;
  endtask

  // Presents s until accepted; returns just after the accepting edge.
  task automatic send(input stim_t s);
    bit acc;
    acc = 1'b0;
    drive(s);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = out_ready_dut;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_ready"}, 64'(out_ready_dut), 64'd1);
    chk({name, "_data"}, {taken, mispredict, misaligned, out_tag}, 64'd0);
    chk({name, "_target"}, 64'(target), 64'd0);
    chk({name, "_link"}, 64'(link), 64'd0);
    chk({name, "_counts"}, {br_count, mp_count}, 64'd0);
  endtask

  // Checks the result of an entry just accepted with no stall downstream.
  task automatic expect_out(input string name, input logic t, input logic [31:0] tg,
                            input logic m);
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_lat_early"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    chk({name, "_lat"}, 64'(out_valid), 64'd1);
    chk({name, "_taken"}, 64'(taken), 64'(t));
    chk({name, "_target"}, 64'(target), 64'(tg));
    chk({name, "_mp"}, 64'(mispredict), 64'(m));
  endtask

  // Cycle counter used to date acceptances and kills.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Input-side recorder: expected result for every accepted entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && in_valid && out_ready_dut) begin
        e = model(mk(kind, func3, r1, r2, pc, imm, pred_taken, pred_target, tag));
        e.cyc = cyc;
        sb_q.push_back(e);
      end
    end
  end

  // Output monitor: scoreboard compare, stall stability, counters.
  initial begin
    exp_t e;
    bit   prev_stall;
    logic [31:0] s_target, s_link;
    logic [8:0]  s_bits;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      chk("br_count", 64'(br_count), STATS ? 64'(32'(exp_br)) : 64'd0);
      chk("mp_count", 64'(mp_count), STATS ? 64'(32'(exp_mp)) : 64'd0);
      if (rst) begin
        kill_cycle = cyc;
        exp_br = 0;
        exp_mp = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (!out_valid || target !== s_target || link !== s_link ||
              {taken, mispredict, misaligned, out_tag} !== s_bits) begin
            failures++;
            $display("FAIL stall_hold: got valid=%0d tgt=%h link=%h bits=%h required valid=1 tgt=%h link=%h bits=%h",
                     out_valid, target, link, {taken, mispredict, misaligned, out_tag},
                     s_target, s_link, s_bits);
          end
        end
        if (out_valid && ds_ready) begin
          while (sb_q.size() > 0 && sb_q[0].cyc <= kill_cycle) void'(sb_q.pop_front());
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output: got tag=%0d required no output", out_tag);
          end else begin
            e = sb_q.pop_front();
            out_count++;
            if (taken !== e.taken || target !== e.target || link !== e.link ||
                mispredict !== e.mp || misaligned !== e.mis || out_tag !== e.tag) begin
              failures++;
              $display("FAIL result: got taken=%0d tgt=%h link=%h mp=%0d mis=%0d tag=%0d required taken=%0d tgt=%h link=%h mp=%0d mis=%0d tag=%0d",
                       taken, target, link, mispredict, misaligned, out_tag,
                       e.taken, e.target, e.link, e.mp, e.mis, e.tag);
            end
            if (e.kind != 2'd3) exp_br++;
            if (e.mp) begin
              exp_mp++;
              kill_cycle = cyc;  // younger in-flight and same-cycle input are wrong-path
            end
          end
        end
        if (flush) kill_cycle = cyc;
        prev_stall = out_valid && !ds_ready && !flush;
        s_target   = target;
        s_link     = link;
        s_bits     = {taken, mispredict, misaligned, out_tag};
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t st[3];
    int acc;
    int base;
    int live;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; ds_ready = 1'b1;
    kind = '0; func3 = '0; r1 = '0; r2 = '0; pc = '0; imm = '0;
    pred_taken = 1'b0; pred_target = '0; tag = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;

    // Directed: BEQ taken, correctly predicted.
    send(mk(2'd0, 3'd0, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120, 6'd1));
    expect_out("beq", 1'b1, 32'h120, 1'b0);
    idle(2);

    // Directed: signed vs unsigned less-than on the same operands.
    send(mk(2'd0, 3'd4, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10, 1'b0, 32'h0, 6'd2));
    expect_out("blt", 1'b1, 32'h210, 1'b1);
    idle(2);
    send(mk(2'd0, 3'd6, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h10, 1'b0, 32'h0, 6'd3));
    expect_out("bltu", 1'b0, 32'h204, 1'b0);
    idle(2);

    // Directed: JALR clears bit 0 but leaves bit 1 set -> misaligned.
    send(mk(2'd2, 3'd0, 32'h203, 32'h0, 32'h40, 32'h0, 1'b1, 32'h202, 6'd4));
    expect_out("jalr", 1'b1, 32'h202, 1'b0);
    chk("jalr_link", 64'(link), 64'h44);
    chk("jalr_mis", 64'(misaligned), 64'd1);
    idle(2);

    // Self-squash: A mispredicts, B and C follow back to back.
    do_reset();
    base = out_count;
    send(mk(2'd0, 3'd0, 32'h1, 32'h2, 32'h300, 32'h40, 1'b1, 32'h340, 6'd5));
    send(mk(2'd1, 3'd0, 32'h0, 32'h0, 32'h304, 32'h100, 1'b1, 32'h404, 6'd6));
    send(mk(2'd1, 3'd0, 32'h0, 32'h0, 32'h308, 32'h100, 1'b1, 32'h408, 6'd7));
    idle(4);
    @(negedge clk);
    chk("squash_outputs", 64'(out_count - base), 64'd1);
    chk("squash_mp_count", 64'(mp_count), STATS ? 64'd1 : 64'd0);
    chk("squash_br_count", 64'(br_count), STATS ? 64'd1 : 64'd0);
    @(posedge clk);
    #1;

    // Back-pressure: 5 cycles of i_ready=0 with three entries offered.
    for (int k = 0; k < 3; k++) st[k] = rand_stim(1'b1, 6'(10 + k));
    ds_ready = 1'b0;
    acc = 0;
    base = out_count;
    for (int k = 0; k < 5; k++) begin
      drive(st[acc]);
      @(negedge clk);
      if (out_ready_dut) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_ready", 64'(out_ready_dut), 64'd0);
    @(posedge clk);
    #1;
    ds_ready = 1'b1;
    idle(4);
    chk("stall_drain", 64'(out_count - base), 64'd2);

    // Flush with both stages full.
    for (int k = 0; k < 2; k++) st[k] = rand_stim(1'b1, 6'(20 + k));
    ds_ready = 1'b0;
    send(st[0]);
    send(st[1]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_pre_valid", 64'(out_valid), 64'd1);
    chk("flush_pre_ready", 64'(out_ready_dut), 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    base = out_count;
    ds_ready = 1'b1;
    idle(3);
    chk("flush_empty", 64'(out_count - base), 64'd0);

    // Reset in the middle of a stream.
    for (int k = 0; k < 3; k++) send(rand_stim(1'b1, 6'(30 + k)));
    @(negedge clk);
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");
    @(posedge clk);
    #1;

    // Randomised traffic with back-pressure and occasional flushes.
    for (int k = 0; k < 3000; k++) begin
      ds_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 49) == 0);
      drive(rand_stim($urandom_range(0, 3) != 0, 6'(tag_n)));
      tag_n++;
      in_valid = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    ds_ready = 1'b1;
    idle(6);

    live = 0;
    foreach (sb_q[i]) if (sb_q[i].cyc > kill_cycle) live++;
    chk("leftover_entries", 64'(live), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Pipelined, parametrised branch resolution unit for the execute stage. It evaluates conditional branches, JAL and JALR on raw register sources. It computes the resolved direction and target, compares them against the front-end prediction, and emits a redirect (mispredict) to fetch. Two registered stages use valid/ready handshakes on both sides. The unit squashes its own wrong-path entries and supports an external flush.

## Interface
Parameters:
- XLEN, 32, datapath width (32 or 64)
- TAG_W, 6, width of the opaque instruction tag carried through

Ports (clock is i_clk; reset is i_rst, synchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_flush  in  1  kill all in-flight entries
- i_valid  in  1  input entry valid
- o_ready  out  1  unit can accept an entry
- i_kind  in  2  00 cond branch, 01 JAL, 10 JALR, 11 non-control
- i_func3  in  3  branch condition (RV encoding)
- i_r1, i_r2  in  XLEN  register sources
- i_pc, i_imm  in  XLEN  instruction PC, sign-extended immediate
- i_pred_taken  in  1  predicted direction
- i_pred_target  in  XLEN  predicted target
- i_tag  in  TAG_W  instruction tag
- o_valid  out  1  result valid
- i_ready  in  1  downstream accepts result
- o_taken  out  1  resolved direction
- o_target  out  XLEN  resolved next PC (target if taken, else pc+4)
- o_link  out  XLEN  pc+4 (rd writeback for JAL/JALR)
- o_mispredict  out  1  redirect required
- o_misaligned  out  1  taken target with target[1:0] != 0
- o_tag  out  TAG_W  tag of the result
- o_br_count, o_mp_count  out  32  statistics counters

## Operation
- Stage E1 (registered): condition evaluation, plus target adder and link adder, all XLEN-wide and modulo 2^XLEN.
  - Conditions: BEQ ==, BNE !=, BLT/BGE signed, BLTU/BGEU unsigned. func3 010/011 evaluate to not taken.
  - JAL and JALR are always taken. Kind 11 is never taken and never mispredicts.
  - Branch and JAL target = pc+imm. JALR target = (r1+imm) & ~1.
- Stage E2 (registered output): resolution.
  - mispredict = (taken != pred_taken) | (taken & target != pred_target).
  - When not taken, o_target = pc+4 and mispredict = pred_taken.
- Handshakes:
  - E1 advances when !E2_valid | i_ready.
  - o_ready = !E1_valid | E1 advances.
  - Input transfers on i_valid & o_ready; output transfers on o_valid & i_ready.
- Self-squash: on an output transfer with o_mispredict=1, the E1 entry is discarded. Any input transferred that same cycle is also discarded. These entries are wrong-path.
- i_flush clears both valid bits at the next edge. Input presented during a flush cycle is dropped. o_ready is unaffected by i_flush.
- All data outputs hold their values while o_valid & !i_ready. Outputs must not change while stalled.

## Timing
- Latency is 2 cycles from input transfer to o_valid, with no stall.
- Throughput is 1 entry per cycle.
- Reset: every output reads 0 after the reset edge, including o_valid, data, flags and counters. o_ready = 1 after reset.
- Reset mid-operation drops all entries; no partial result is emitted.
- If flush and an output transfer occur in the same cycle, the transfer completes and is counted, and both stages are empty afterwards.

## Configuration
- BRANCH_RESOLVE_STATS_EN defined:
  - o_br_count increments on each output transfer with i_kind != 11.
  - o_mp_count increments on each output transfer with o_mispredict=1.
  - Both counters are 32-bit, wrap modulo 2^32, are cleared only by i_rst, and are unaffected by i_flush.
- Not defined: counters are not synthesised and both outputs are tied to 0.

## Test plan
- BEQ, r1=r2=0x5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> 2 cycles later: o_taken=1, o_target=0x120, o_mispredict=0.
- BLT, r1=0xFFFFFFFF, r2=1, pred_taken=0 -> taken=1, mispredict=1. Same operands with BLTU -> taken=0, o_target=pc+4, mispredict=0.
- JALR, r1=0x203, imm=0, pc=0x40 -> o_target=0x202, o_link=0x44, o_misaligned=1.
- Mispredicting entry A followed back-to-back by B and C, i_ready=1 -> only A emitted. B is squashed and C is dropped. o_mp_count=1 and o_br_count=1 with the macro defined.
- i_ready=0 for 5 cycles with 3 inputs offered -> 2 accepted and o_ready=0. Outputs are stable while stalled. Releasing i_ready emits both entries in order with no loss or duplication.
- i_flush with both stages full, then i_rst asserted mid-stream -> o_valid=0 the next cycle in each case. After reset, all outputs and counters read 0 and o_ready=1.
